// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. It feeds an 8-bit holding register
// through data_out/load and flags frames whose stop bit is low.
module uart_rx #(
    parameter int BAUD_DIV  = 54,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       load,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    samp_cnt;
    logic [BW-1:0] bit_idx;
    logic [7:0]    shreg;

    // Synchroniser resets to the idle-line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (tick_cnt == TW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            load     <= 1'b0;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        // Restart the oversample phase at the falling edge.
                        state    <= START;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                        samp_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (samp_cnt == 4'd7) begin
                            samp_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + 4'd1;
                        if (samp_cnt == 4'd15) begin
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_idx <= bit_idx + BW'(1);
                            if (bit_idx == BW'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + 4'd1;
                        if (samp_cnt == 4'd15) begin
                            if (rx_s) begin
                                data_out  <= shreg;
                                load      <= 1'b1;
                                frame_err <= 1'b0;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomized 8N1 frames checked against a
// queue of expected bytes and a level model of data_out/frame_err.
module tb_uart_rx;

    localparam int BD  = 4;
    localparam int BIT = 16 * BD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       load;
    logic       frame_err;
    logic       busy;

    uart_rx #(.BAUD_DIV(BD), .DATA_BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data_out(data_out),
        .load(load),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         start;
        int         period;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic [7:0] load_log[$];
    logic [7:0] model_data = 8'h00;
    logic       model_ferr = 1'b0;
    int         last_start = 0;
    int         load_count = 0;
    int         exp_loads = 0;
    int         last_load_lat = -1;
    int         last_busy_lat = -1;
    logic       prev_load = 1'b0;
    logic       prev_busy = 1'b0;
    exp_t       mon_e;
    int         mon_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare process: every negedge the DUT outputs are set against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("reset_outputs", {data_out, load, frame_err, busy}, 32'h0);
            prev_load = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (load) begin
                load_count++;
                load_log.push_back(data_out);
                check("load_not_consecutive", prev_load, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: data_out=%02h, no good frame pending", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    model_data = mon_e.data;
                    model_ferr = 1'b0;
                    mon_lat = cyc - mon_e.start;
                    last_load_lat = mon_lat;
                    checks++;
                    if (mon_lat < 9 * mon_e.period || mon_lat > 10 * mon_e.period + 4) begin
                        errors++;
                        $display("FAIL load_latency: got %0d clk, expected within stop bit [%0d,%0d]",
                                 mon_lat, 9 * mon_e.period, 10 * mon_e.period + 4);
                    end
                    check("load_frame_err", frame_err, 1'b0);
                end
            end
            check("data_out", data_out, model_data);
            if (!busy) check("frame_err", frame_err, model_ferr);
            if (prev_load) check("busy_after_load", busy, 1'b0);
            if (busy && !prev_busy) begin
                mon_lat = cyc - last_start;
                last_busy_lat = mon_lat;
                checks++;
                if (mon_lat < 2 || mon_lat > 4) begin
                    errors++;
                    $display("FAIL busy_rise: got %0d clk after start edge, expected 2..4", mon_lat);
                end
            end
            prev_load = load;
            prev_busy = busy;
        end
    end

    task automatic idle(input int bits, input int p);
        rx = 1'b1;
        repeat (bits * p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
        exp_t e;
        if (stop) begin
            e.data = d;
            e.start = cyc;
            e.period = p;
            exp_q.push_back(e);
            exp_loads++;
        end
        last_start = cyc;
        rx = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (p) @(negedge clk);
        end
        rx = stop;
        repeat (p) @(negedge clk);
        if (!stop) model_ferr = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] abort_byte;
        logic [7:0] d;
        logic       stop;
        int         p;
        int         gap;
        int         wait_cnt;

        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_busy", busy, 1'b0);
        reset = 1'b1;
        idle(2, BIT);

        // Start-bit glitch: 12 clk low is far shorter than half a bit.
        last_start = cyc;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        check("glitch_busy", busy, 1'b0);
        check("glitch_data_out", data_out, 8'h00);
        check("glitch_loads", load_count, 0);

        send_frame(8'hA5, 1'b1, BIT);
        idle(1, BIT);
        check("a5_data_out", data_out, 8'hA5);
        check("a5_loads", load_count, 1);
        check("a5_load_latency", last_load_lat, 611);
        check("a5_busy_latency", last_busy_lat, 3);
        check("a5_frame_err", frame_err, 1'b0);

        // Bad stop bit followed by a 20-bit break.
        send_frame(8'h3C, 1'b0, BIT);
        repeat (20 * BIT) @(negedge clk);
        check("break_frame_err", frame_err, 1'b1);
        check("break_busy", busy, 1'b1);
        check("break_data_out", data_out, 8'hA5);
        check("break_loads", load_count, 1);
        idle(2, BIT);
        check("break_end_busy", busy, 1'b0);
        check("break_end_frame_err", frame_err, 1'b1);
        send_frame(8'hFF, 1'b1, BIT);
        idle(1, BIT);
        check("ff_data_out", data_out, 8'hFF);
        check("ff_frame_err", frame_err, 1'b0);
        check("ff_loads", load_count, 2);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        idle(2, BIT);
        check("b2b_loads", load_count, 4);
        check("b2b_first", load_log[2], 8'h00);
        check("b2b_second", load_log[3], 8'hFF);

        // Reset pulse in the middle of data bit 4 of 0x81.
        abort_byte = 8'h81;
        last_start = cyc;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            repeat (BIT) @(negedge clk);
        end
        rx = abort_byte[4];
        repeat (BIT / 2) @(negedge clk);
        @(posedge clk);
        #2;
        model_data = 8'h00;
        model_ferr = 1'b0;
        reset = 1'b0;
        rx = 1'b1;
        #1;
        check("midreset_outputs", {data_out, load, frame_err, busy}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        idle(12, BIT);
        check("midreset_loads", load_count, 4);
        check("midreset_data_out", data_out, 8'h00);
        send_frame(8'h5A, 1'b1, BIT);
        idle(1, BIT);
        check("post_reset_data_out", data_out, 8'h5A);

        // Baud skew: slow and fast transmitters.
        send_frame(8'h55, 1'b1, 61);
        idle(1, 61);
        send_frame(8'hAA, 1'b1, 67);
        idle(1, 67);
        check("skew_loads", load_count, 7);
        check("skew_first", load_log[5], 8'h55);
        check("skew_second", load_log[6], 8'hAA);

        // Randomized frames, occasional bad stop bits, small baud error.
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom);
            p = int'($urandom_range(62, 66));
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, stop, p);
            gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            idle(gap, p);
        end
        idle(2, BIT);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("queue_drained", exp_q.size(), 0);
        check("total_loads", load_count, exp_loads);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
